// File: rtl/id_stage.sv
// id_stage: instruction decode with IF/ID latch, 32x32 register file with
// write-through bypass, and load-use hazard detection.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_if,
    input  logic [31:0] npc_if,
    input  logic        flush,
    input  logic [5:0]  ex_op,
    input  logic [4:0]  ex_ri,
    input  logic        wb_en,
    input  logic [4:0]  wb_ri,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic [5:0]  op_id,
    output logic [31:0] A_id,
    output logic [31:0] B_id,
    output logic [31:0] Imm_id,
    output logic [31:0] npc_id,
    output logic [31:0] Ri_id
);
    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_ADDI  = 6'b001000;
    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_SW    = 6'b101011;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [5:0]  OP_J     = 6'b000010;
    localparam logic [5:0]  OP_NOP   = 6'b111111;
    localparam logic [31:0] NOP_INSTR = 32'hFC000000;

    logic [31:0] r_instr;
    logic [31:0] r_npc;
    logic [31:0] r_regs [32];

    logic [5:0]  w_op_raw;
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_dest;
    logic        w_uses_rs;
    logic        w_uses_rt;
    logic        w_wr;

    assign w_op_raw = r_instr[31:26];
    assign w_rs     = r_instr[25:21];
    assign w_rt     = r_instr[20:16];
    assign w_rd     = r_instr[15:11];
    assign w_wr     = wb_en && (wb_ri != 5'd0);

    always_comb begin
        w_op = (w_op_raw == OP_RTYPE || w_op_raw == OP_ADDI || w_op_raw == OP_LW ||
                w_op_raw == OP_SW || w_op_raw == OP_BEQ || w_op_raw == OP_J) ? w_op_raw : OP_NOP;
        w_dest = (w_op == OP_RTYPE) ? w_rd :
                 (w_op == OP_ADDI || w_op == OP_LW) ? w_rt : 5'd0;
        w_uses_rs = (w_op == OP_RTYPE || w_op == OP_ADDI || w_op == OP_LW ||
                     w_op == OP_SW || w_op == OP_BEQ);
        w_uses_rt = (w_op == OP_RTYPE || w_op == OP_SW || w_op == OP_BEQ);
        // flush kills the decoded instruction, so its hazard is irrelevant
        stall = !flush && (ex_op == OP_LW) && (ex_ri != 5'd0) &&
                ((w_uses_rs && ex_ri == w_rs) || (w_uses_rt && ex_ri == w_rt));
        op_id  = stall ? OP_NOP : w_op;
        Ri_id  = stall ? 32'd0 : {27'd0, w_dest};
        A_id   = (w_rs == 5'd0) ? 32'd0 : (w_wr && wb_ri == w_rs) ? wb_data : r_regs[w_rs];
        B_id   = (w_rt == 5'd0) ? 32'd0 : (w_wr && wb_ri == w_rt) ? wb_data : r_regs[w_rt];
        Imm_id = {{16{r_instr[15]}}, r_instr[15:0]};
        npc_id = r_npc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= NOP_INSTR;
            r_npc   <= 32'd0;
        end else if (flush) begin
            r_instr <= NOP_INSTR;
            r_npc   <= 32'd0;
        end else if (!stall) begin
            r_instr <= instr_if;
            r_npc   <= npc_if;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else if (w_wr) begin
            r_regs[wb_ri] <= wb_data;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of decode, bypass, load-use stall, flush and reset.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst, flush, wb_en, stall;
    logic [31:0] instr_if, npc_if, wb_data, A_id, B_id, Imm_id, npc_id, Ri_id;
    logic [5:0]  ex_op, op_id;
    logic [4:0]  ex_ri, wb_ri;
    int n_cmp = 0;
    int n_err = 0;

    id_stage dut (
        .clk(clk), .rst(rst), .instr_if(instr_if), .npc_if(npc_if), .flush(flush),
        .ex_op(ex_op), .ex_ri(ex_ri), .wb_en(wb_en), .wb_ri(wb_ri), .wb_data(wb_data),
        .stall(stall), .op_id(op_id), .A_id(A_id), .B_id(B_id), .Imm_id(Imm_id),
        .npc_id(npc_id), .Ri_id(Ri_id)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd);
        return {6'b000000, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        rst = 1; flush = 0; wb_en = 0; wb_ri = 0; wb_data = 0;
        ex_op = 6'h3F; ex_ri = 0; instr_if = 32'hFC000000; npc_if = 0;
        tick;
        rst = 0;
        // preload reg9 and prove it is readable
        wb_en = 1; wb_ri = 9; wb_data = 32'h12345678;
        instr_if = rtype(9, 0, 1); npc_if = 32'h10;
        tick;
        wb_en = 0;
        #1;
        check("preload_A", A_id, 32'h12345678);
        // reset with prior contents
        rst = 1;
        tick;
        rst = 0;
        #1;
        check("rst_op", op_id, 32'h3F);
        check("rst_ri", Ri_id, 0);
        check("rst_A", A_id, 0);
        check("rst_B", B_id, 0);
        check("rst_imm", Imm_id, 0);
        check("rst_npc", npc_id, 0);
        check("rst_stall", stall, 0);
        tick;
        check("rst_reg9", A_id, 0);
        check("rst_op_rtype", op_id, 0);
        // ADDI decode with negative immediate
        instr_if = itype(6'b001000, 0, 5, 16'hFFFE); npc_if = 32'h104;
        tick;
        check("addi_op", op_id, 32'h08);
        check("addi_imm", Imm_id, 32'hFFFFFFFE);
        check("addi_ri", Ri_id, 5);
        check("addi_npc", npc_id, 32'h104);
        // write-through bypass
        instr_if = rtype(3, 0, 7); npc_if = 32'h108;
        tick;
        wb_en = 1; wb_ri = 3; wb_data = 32'hDEADBEEF;
        #1;
        check("byp_A", A_id, 32'hDEADBEEF);
        check("byp_B", B_id, 0);
        check("byp_ri", Ri_id, 7);
        tick;
        wb_ri = 0; wb_data = 32'h55;
        #1;
        check("reg3_stored", A_id, 32'hDEADBEEF);
        check("r0_byp", B_id, 0);
        tick;
        wb_en = 0;
        #1;
        check("r0_after", B_id, 0);
        // unknown opcode decodes as NOP
        instr_if = itype(6'b010101, 1, 6, 16'h1); npc_if = 32'h10C;
        tick;
        check("unk_op", op_id, 32'h3F);
        check("unk_ri", Ri_id, 0);
        // load-use on rs
        instr_if = rtype(4, 2, 10); npc_if = 32'h200;
        tick;
        instr_if = itype(6'b001000, 0, 11, 16'h1); npc_if = 32'h204;
        ex_op = 6'b100011; ex_ri = 4;
        #1;
        check("lu_stall", stall, 1);
        check("lu_op", op_id, 32'h3F);
        check("lu_ri", Ri_id, 0);
        tick;
        ex_op = 6'h3F; ex_ri = 0;
        #1;
        check("lu_release", stall, 0);
        check("lu_held_op", op_id, 0);
        check("lu_held_ri", Ri_id, 10);
        check("lu_held_npc", npc_id, 32'h200);
        tick;
        check("lu_next_op", op_id, 32'h08);
        check("lu_next_ri", Ri_id, 11);
        // ADDI does not read rt; ex_ri=0 never stalls
        ex_op = 6'b100011; ex_ri = 11;
        #1;
        check("addi_rt_nostall", stall, 0);
        ex_ri = 0;
        #1;
        check("ri0_nostall", stall, 0);
        // SW stalls on rt
        instr_if = itype(6'b101011, 1, 13, 16'h4); npc_if = 32'h208;
        ex_op = 6'h3F;
        tick;
        ex_op = 6'b100011; ex_ri = 13;
        #1;
        check("sw_rt_stall", stall, 1);
        // flush priority over stall
        ex_op = 6'h3F; ex_ri = 0;
        instr_if = rtype(4, 2, 10); npc_if = 32'h300;
        tick;
        ex_op = 6'b100011; ex_ri = 4; flush = 1;
        #1;
        check("fl_stall", stall, 0);
        tick;
        flush = 0; ex_op = 6'h3F; ex_ri = 0;
        #1;
        check("fl_op", op_id, 32'h3F);
        check("fl_ri", Ri_id, 0);
        check("fl_npc", npc_id, 0);
        // write and stall in the same cycle
        instr_if = rtype(4, 12, 10); npc_if = 32'h400;
        tick;
        instr_if = 32'hFC000000; npc_if = 32'h404;
        ex_op = 6'b100011; ex_ri = 4;
        wb_en = 1; wb_ri = 12; wb_data = 32'h77;
        #1;
        check("ws_stall", stall, 1);
        tick;
        wb_en = 0; ex_op = 6'h3F; ex_ri = 0;
        #1;
        check("ws_op", op_id, 0);
        check("ws_B", B_id, 32'h77);
        // reset mid-stall
        ex_op = 6'b100011; ex_ri = 4;
        #1;
        check("rs_stall", stall, 1);
        rst = 1;
        tick;
        rst = 0;
        #1;
        check("rs_stall0", stall, 0);
        check("rs_op", op_id, 32'h3F);
        ex_op = 6'h3F; ex_ri = 0;
        instr_if = rtype(4, 12, 10);
        tick;
        check("rs_reg12", B_id, 0);
        check("rs_op2", op_id, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port: instr_if  input  32  fetched instruction from the fetch stage.
REQ-004 SHALL have port: npc_if  input  32  PC+4 of instr_if.
REQ-005 SHALL have port: flush  input  1  branch/jump taken in EX; kill the instruction held in decode.
REQ-006 SHALL have port: ex_op  input  6  opcode currently in EX (op_ex of the ID/EX register).
REQ-007 SHALL have port: ex_ri  input  5  destination register currently in EX (Ri_ex).
REQ-008 SHALL have port: wb_en, wb_ri, wb_data  input  1/5/32  write-back enable, destination index, data.
REQ-009 SHALL have port: stall  output  1  hold request to fetch stage (PC and instr_if held by fetch).
REQ-010 SHALL have port: op_id  output  6  decoded opcode to the ID/EX register.
REQ-011 SHALL have port: A_id, B_id  output  32 each  rs and rt operand values.
REQ-012 SHALL have port: Imm_id  output  32  sign-extended immediate.
REQ-013 SHALL have port: npc_id  output  32  PC+4 of the decoded instruction.
REQ-014 SHALL have port: Ri_id  output  32  destination register index, zero-extended from 5 bits.

Function
REQ-015 SHALL hold an internal IF/ID latch (instr_q, npc_q) loaded from instr_if/npc_if each rising edge unless stall or flush applies.
REQ-016 SHALL decode instr_q: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]; Imm_id = {16{imm[15]},imm}.
REQ-017 SHALL recognise opcodes: RTYPE 000000, ADDI 001000, LW 100011, SW 101011, BEQ 000100, J 000010, NOP 111111; any other opcode SHALL be output as NOP.
REQ-018 SHALL set destination: RTYPE -> rd; ADDI, LW -> rt; SW, BEQ, J, NOP -> 0.
REQ-019 SHALL contain a 32x32 register file; register 0 reads 0 always and writes to it are ignored.
REQ-020 SHALL write wb_data to reg[wb_ri] at rising edge when wb_en=1 and wb_ri!=0.
REQ-021 SHALL read A_id/B_id combinationally with write-through bypass: if wb_en=1, wb_ri!=0 and wb_ri equals rs (rt), A_id (B_id) = wb_data in the same cycle.
REQ-022 SHALL assert stall combinationally when ex_op=LW, ex_ri!=0, and ex_ri equals rs (for RTYPE, ADDI, LW, SW, BEQ) or rt (for RTYPE, SW, BEQ).
REQ-023 While stall=1: IF/ID latch SHALL hold; op_id SHALL be NOP, Ri_id=0, A_id/B_id/Imm_id/npc_id unconstrained; next cycle the held instruction re-decodes (single-cycle bubble since LW leaves EX).
REQ-024 When flush=1: IF/ID latch SHALL load NOP (instr_q=32'hFC000000, npc_q=0) at the next edge; stall SHALL be forced 0 in that cycle; flush takes priority over stall.
REQ-025 Decode outputs SHALL be combinational from instr_q/npc_q and register file; latency instr_if -> op_id is exactly one clock.
REQ-026 Register-file write and IF/ID update SHALL be independent; a write and a stall in the same cycle SHALL both take effect.

Reset
REQ-027 On rst=1 at a rising edge: instr_q SHALL become 32'hFC000000 (NOP), npc_q=0, all 32 registers=0; takes priority over flush and stall.
REQ-028 After reset and before the first new fetch, outputs SHALL be op_id=NOP, A_id=B_id=Imm_id=npc_id=Ri_id=0, stall=0.

Verification
REQ-029 Reset: rst=1 one cycle with prior register contents -> op_id=111111, Ri_id=0, reading any register returns 0.
REQ-030 Decode/imm: instr_if=ADDI rt=5 rs=0 imm=16'hFFFE, npc_if=0x104 -> next cycle op_id=001000, Imm_id=0xFFFFFFFE, Ri_id=5, npc_id=0x104.
REQ-031 Bypass: wb_en=1, wb_ri=3, wb_data=0xDEADBEEF while instr_q=RTYPE rs=3 rt=0 rd=7 -> A_id=0xDEADBEEF same cycle, B_id=0, Ri_id=7; wb_ri=0 write -> reg0 still reads 0.
REQ-032 Load-use: ex_op=100011, ex_ri=4, instr_q=RTYPE rs=4 -> stall=1, op_id=NOP for one cycle, instr_q unchanged; ex_op=NOP next cycle -> stall=0, RTYPE decoded.
REQ-033 Flush priority: flush=1 and load-use condition in same cycle -> stall=0, next cycle op_id=NOP, Ri_id=0.
REQ-034 Reset mid-stall: rst=1 while stall=1 -> next cycle instr_q=NOP, registers zero, stall=0.
